// File: rtl/tabela_varredura_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tabela_varredura_if : row stream (input vector, output bit) with valid/ready
// Rev 1.0
// ---------------------------------------------------------------------------
interface tabela_varredura_if #(
  parameter int N = 2
);
  logic [N-1:0] in_vec;
  logic         s;
  logic         valid;
  logic         ready;

  modport master (output in_vec, output s, output valid, input ready);
  modport slave  (input in_vec, input s, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/tabela_varredura.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tabela_varredura : sweeps a snapshotted N-input LUT, streams every row and
//                    scores it against an expected table. Rev 1.0
// ---------------------------------------------------------------------------
module tabela_varredura #(
  parameter  int N    = 2,
  localparam int ROWS = 2**N
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            start_i,
  input  wire logic [ROWS-1:0] lut_i,
  input  wire logic [ROWS-1:0] expected_i,
  tabela_varredura_if.master   row_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [N:0]           ones_count_o,
  output logic                 equal_o,
  output logic [N-1:0]         first_mismatch_o
);

  localparam int           CW       = N + 1;
  localparam logic [N-1:0] LAST_IDX = N'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    idx_q;
  logic [N-1:0]    idx_d;
  logic [ROWS-1:0] lut_q;
  logic [ROWS-1:0] exp_q;
  logic            s_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic [N:0]      ones_q;
  logic            equal_q;
  logic [N-1:0]    first_q;
  logic            seen_q;
  logic            row_mismatch;

  assign idx_d        = idx_q + N'(1);
  assign row_mismatch = s_q ^ exp_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lut_q   <= '0;
      exp_q   <= '0;
      s_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
      equal_q <= 1'b0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            // Tables are captured here so callers may change them mid-sweep
            lut_q   <= lut_i;
            exp_q   <= expected_i;
            ones_q  <= '0;
            equal_q <= 1'b1;
            first_q <= '0;
            seen_q  <= 1'b0;
            idx_q   <= '0;
            s_q     <= lut_i[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SWEEP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SWEEP: begin
          if (valid_q && row_o.ready) begin
            ones_q <= ones_q + CW'(s_q);
            if (row_mismatch) begin
              equal_q <= 1'b0;
              if (!seen_q) begin
                first_q <= idx_q;
                seen_q  <= 1'b1;
              end
            end
            // Terminal compare keeps the N-bit counter from wrapping back to 0
            if (idx_q == LAST_IDX) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_d;
              s_q   <= lut_q[idx_d];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign row_o.in_vec     = idx_q;
  assign row_o.s          = s_q;
  assign row_o.valid      = valid_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign ones_count_o     = ones_q;
  assign equal_o          = equal_q;
  assign first_mismatch_o = first_q;

endmodule
`default_nettype wire

// File: tb/tb_tabela_varredura.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tabela_varredura : directed + random sweeps on N=2 and N=8 instances,
//                       scored against a table-level reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_tabela_varredura;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic         sel8;
  logic [255:0] lut_v;
  logic [255:0] exp_v;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  tabela_varredura_if #(.N(2)) if2 ();
  tabela_varredura_if #(.N(8)) if8 ();
  assign if2.ready = ready;
  assign if8.ready = ready;

  logic       busy2, done2, eq2, busy8, done8, eq8;
  logic [2:0] ones2;
  logic [1:0] fm2;
  logic [8:0] ones8;
  logic [7:0] fm8;

  tabela_varredura #(.N(2)) u_dut2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start & ~sel8),
    .lut_i            (lut_v[3:0]),
    .expected_i       (exp_v[3:0]),
    .row_o            (if2),
    .busy_o           (busy2),
    .done_o           (done2),
    .ones_count_o     (ones2),
    .equal_o          (eq2),
    .first_mismatch_o (fm2)
  );

  tabela_varredura #(.N(8)) u_dut8 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start & sel8),
    .lut_i            (lut_v),
    .expected_i       (exp_v),
    .row_o            (if8),
    .busy_o           (busy8),
    .done_o           (done8),
    .ones_count_o     (ones8),
    .equal_o          (eq8),
    .first_mismatch_o (fm8)
  );

  logic [7:0] obs_vec, obs_fm;
  logic [8:0] obs_ones;
  logic       obs_s, obs_valid, obs_busy, obs_done, obs_eq;
  assign obs_vec   = sel8 ? if8.in_vec : {6'd0, if2.in_vec};
  assign obs_s     = sel8 ? if8.s      : if2.s;
  assign obs_valid = sel8 ? if8.valid  : if2.valid;
  assign obs_busy  = sel8 ? busy8      : busy2;
  assign obs_done  = sel8 ? done8      : done2;
  assign obs_eq    = sel8 ? eq8        : eq2;
  assign obs_ones  = sel8 ? ones8      : {6'd0, ones2};
  assign obs_fm    = sel8 ? fm8        : {6'd0, fm2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-table properties of the snapshotted function
  function automatic int model_ones(input logic [255:0] l, input int rows);
    int c = 0;
    for (int i = 0; i < rows; i++) c += int'(l[i]);
    return c;
  endfunction

  function automatic int model_first(input logic [255:0] l, input logic [255:0] e, input int rows);
    for (int i = 0; i < rows; i++) if (l[i] != e[i]) return i;
    return 0;
  endfunction

  function automatic int model_equal(input logic [255:0] l, input logic [255:0] e, input int rows);
    for (int i = 0; i < rows; i++) if (l[i] != e[i]) return 0;
    return 1;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_results(input string tag, input logic [255:0] l,
                               input logic [255:0] e, input int rows);
    check({tag, "_ones"},  32'(obs_ones), model_ones(l, rows));
    check({tag, "_equal"}, 32'(obs_eq),   model_equal(l, e, rows));
    check({tag, "_first"}, 32'(obs_fm),   model_first(l, e, rows));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"},   32'(obs_vec),   0);
    check({tag, "_s"},     32'(obs_s),     0);
    check({tag, "_valid"}, 32'(obs_valid), 0);
    check({tag, "_busy"},  32'(obs_busy),  0);
    check({tag, "_done"},  32'(obs_done),  0);
    check({tag, "_ones"},  32'(obs_ones),  0);
    check({tag, "_equal"}, 32'(obs_eq),    0);
    check({tag, "_first"}, 32'(obs_fm),    0);
  endtask

  // Called at a negedge; asserts start there and ends on the done negedge.
  task automatic run_sweep(input logic [255:0] l, input logic [255:0] e, input int rows,
                           input bit rnd_ready, input int stall_row, input int stall_len,
                           input int mid_start_row, input int abort_row);
    int r       = 0;
    int cyc     = 1;
    int stalled = 0;
    lut_v = l;
    exp_v = e;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lut_v = ~l;
    exp_v = ~e;
    while (r < rows) begin
      if (cyc > rows * 8 + 40) begin
        check("sweep_timeout", 1, 0);
        return;
      end
      check("row_valid", 32'(obs_valid), 1);
      check("row_busy",  32'(obs_busy),  1);
      check("row_done",  32'(obs_done),  0);
      check("row_vec",   32'(obs_vec),   r);
      check("row_s",     32'(obs_s),     32'(l[r]));
      if (r == abort_row) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = (r == mid_start_row);
      if (r == stall_row && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
      end else begin
        ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (ready) r++;
    end
    start = 1'b0;
    ready = 1'b1;
    check("done_pulse", 32'(obs_done),  1);
    check("done_valid", 32'(obs_valid), 0);
    check("done_busy",  32'(obs_busy),  0);
    check_results("done", l, e, rows);
    if (!rnd_ready && stall_len == 0 && mid_start_row < 0)
      check("latency", cyc, rows + 1);
  endtask

  task automatic idle_step(input logic [255:0] l, input logic [255:0] e, input int rows);
    @(negedge clk);
    check("idle_done",  32'(obs_done),  0);
    check("idle_busy",  32'(obs_busy),  0);
    check("idle_valid", 32'(obs_valid), 0);
    check_results("idle", l, e, rows);
  endtask

  initial begin
    logic [255:0] l, e;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    sel8  = 1'b0;
    lut_v = '0;
    exp_v = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset2");
    sel8 = 1'b1;
    #1;
    check_all_zero("reset8");
    sel8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // N=2 directed: s=q, then s=p against a mismatching table
    run_sweep(256'ha, 256'ha, 4, 0, -1, 0, -1, -1);
    idle_step(256'ha, 256'ha, 4);
    run_sweep(256'hc, 256'h7, 4, 0, -1, 0, -1, -1);
    idle_step(256'hc, 256'h7, 4);

    // Backpressure on row 01 for three cycles
    run_sweep(256'h7, 256'h7, 4, 0, 1, 3, -1, -1);
    idle_step(256'h7, 256'h7, 4);

    // Start mid-sweep is ignored; start on the done cycle relaunches
    run_sweep(256'h5, 256'h4, 4, 0, -1, 0, 2, -1);
    run_sweep(256'h9, 256'h3, 4, 0, -1, 0, -1, -1);
    idle_step(256'h9, 256'h3, 4);

    // N=2 random tables and random ready, alternately chained
    for (int k = 0; k < 10; k++) begin
      l = rand256();
      e = (k % 3 == 0) ? l : rand256();
      run_sweep(l, e, 4, 1, -1, 0, -1, -1);
      if (k % 2 == 1) idle_step(l, e, 4);
    end
    idle_step(l, e, 4);

    // N=8: all ones must reach 256 without wrapping
    sel8 = 1'b1;
    @(negedge clk);
    run_sweep({256{1'b1}}, {256{1'b1}}, 256, 0, -1, 0, -1, -1);
    idle_step({256{1'b1}}, {256{1'b1}}, 256);

    // Asynchronous reset during row 4 discards the sweep
    run_sweep(rand256(), rand256(), 256, 0, -1, 0, -1, 4);
    @(negedge clk);
    check_all_zero("post_rst");

    // N=8 random sweeps with a late single-bit difference and random ready
    for (int k = 0; k < 2; k++) begin
      l = rand256();
      e = l;
      e[200 - k * 50] = ~e[200 - k * 50];
      run_sweep(l, e, 256, 1, -1, 0, -1, -1);
      idle_step(l, e, 256);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
